mem_access_unit: RTL and testbench

- Stage directly downstream of the execute unit: takes its ALU result, register-writeback fields and memory-request fields, performs the data-memory access over a req/ack bus, and produces a registered writeback packet for the WB stage.
- Handles byte-lane steering for stores and lane extraction plus sign/zero extension for loads.
- Back-pressures the upstream pipeline with `in_ready` while an access is outstanding.

---
 rtl/mem_access_unit_if.sv | 29 ++
 rtl/mem_access_unit.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_unit_if.sv
// Data-memory req/ack bus between mem_access_unit (master) and the data memory (slave).
//
// Signals:
//   dm_req    master -> slave  access request, held until dm_ack
//   dm_we     master -> slave  1 = write
//   dm_addr   master -> slave  word-aligned byte address
//   dm_wdata  master -> slave  lane-steered store data
//   dm_wstrb  master -> slave  byte strobes
//   dm_rdata  slave -> master  read data, valid with dm_ack
//   dm_ack    slave -> master  access complete
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic [31:0] dm_rdata;
    logic        dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access pipeline stage: takes execute results, performs the data-memory access over a
// req/ack bus (byte-lane steering for stores, lane extraction and extension for loads) and emits a
// registered writeback packet. in_ready back-pressures upstream while an access is outstanding.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  upstream handshake
//   alu_data_i .. regc_addr_i  upstream packet fields
//   bus                  data-memory bus (mem_access_unit_if.master)
//   wb_valid, wb_data, wb_addr, wb_wr  writeback packet (wb_valid is a one-cycle pulse)
//   misalign             one-cycle pulse on a misaligned access
//   timeout_err          one-cycle pulse on an ack timeout (only with MEM_TIMEOUT_EN)
//
// Build option: define MEM_TIMEOUT_EN to abort an access not acked within TIMEOUT_CYCLES cycles.
module mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_rd_i,
    input  logic        mem_wr_i,
    input  logic [3:0]  rmask_i,
    input  logic [3:0]  wmask_i,
    input  logic        load_signed_i,
    input  logic        regc_wr_i,
    input  logic [4:0]  regc_addr_i,
    mem_access_unit_if.master bus,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_addr,
    output logic        wb_wr,
`ifdef MEM_TIMEOUT_EN
    output logic        timeout_err,
`endif
    output logic        misalign
);

    localparam logic [3:0]  MaskHalf = 4'b0011;
    localparam logic [3:0]  MaskWord = 4'b1111;
    localparam logic [31:0] TimeoutData = 32'hDEADBEEF;

    typedef enum logic [1:0] {StIdle, StReq, StResp} state_e;

    state_e state_q, state_d;

    // Fields latched at accept for the outstanding access
    logic [31:0] addr_q, addr_d;
    logic        we_q, we_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [1:0]  ld_off_q, ld_off_d;
    logic [3:0]  ld_mask_q, ld_mask_d;
    logic        ld_signed_q, ld_signed_d;
    logic        ld_en_q, ld_en_d;
    logic [31:0] alu_q, alu_d;
    logic        regc_wr_q, regc_wr_d;
    logic [4:0]  regc_addr_q, regc_addr_d;

    logic        wb_valid_q, wb_valid_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_addr_q, wb_addr_d;
    logic        wb_wr_q, wb_wr_d;
    logic        misalign_q, misalign_d;

    logic        accept;
    logic        in_is_mem;
    logic [1:0]  in_off;
    logic [3:0]  acc_mask;
    logic        in_misalign;
    logic [31:0] steered_wdata;
    logic [31:0] rdata_shifted;
    logic [31:0] load_value;
    logic        timeout_hit;

    // Input decode
    always_comb begin
        in_off    = mem_addr_i[1:0];
        in_is_mem = mem_rd_i | mem_wr_i;
        // Store wins when both requests are set, so its size decides alignment
        acc_mask  = mem_wr_i ? wmask_i : rmask_i;
        in_misalign = in_is_mem &&
                      (((acc_mask == MaskHalf) && in_off[0]) ||
                       ((acc_mask == MaskWord) && (in_off != 2'b00)));
        unique case (wmask_i)
            MaskWord: steered_wdata = mem_wdata_i;
            MaskHalf: steered_wdata = {2{mem_wdata_i[15:0]}};
            default:  steered_wdata = {4{mem_wdata_i[7:0]}};
        endcase
    end

    // Load lane extraction and extension from the live bus data
    always_comb begin
        rdata_shifted = bus.dm_rdata >> {ld_off_q, 3'b000};
        unique case (ld_mask_q)
            MaskWord: load_value = bus.dm_rdata;
            MaskHalf: begin
                load_value[15:0]  = ld_off_q[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
                load_value[31:16] = {16{ld_signed_q & load_value[15]}};
            end
            default: load_value = {{24{ld_signed_q & rdata_shifted[7]}}, rdata_shifted[7:0]};
        endcase
    end

`ifdef MEM_TIMEOUT_EN
    localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] cnt_q, cnt_d;
    logic        timeout_q, timeout_d;

    always_comb begin
        cnt_d       = (state_q == StReq) ? cnt_q + 16'd1 : 16'd0;
        timeout_hit = (state_q == StReq) && !bus.dm_ack && (cnt_q == TimeoutLast);
        timeout_d   = timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= 16'd0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_err = timeout_q;
`else
    // Without the timeout feature TIMEOUT_CYCLES is inert
    if (TIMEOUT_CYCLES > 0) begin : g_no_timeout
    end
    assign timeout_hit = 1'b0;
`endif

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (accept && in_is_mem && !in_misalign) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                if (bus.dm_ack) begin
                    state_d = StResp;
                end else if (timeout_hit) begin
                    state_d = StIdle;
                end
            end
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // FSM: outputs and datapath next values
    always_comb begin
        in_ready = (state_q == StIdle) && !rst;
        accept   = in_valid && in_ready;

        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        ld_off_d    = ld_off_q;
        ld_mask_d   = ld_mask_q;
        ld_signed_d = ld_signed_q;
        ld_en_d     = ld_en_q;
        alu_d       = alu_q;
        regc_wr_d   = regc_wr_q;
        regc_addr_d = regc_addr_q;

        wb_valid_d = 1'b0;
        wb_data_d  = wb_data_q;
        wb_addr_d  = wb_addr_q;
        wb_wr_d    = wb_wr_q;
        misalign_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!in_is_mem || in_misalign) begin
                        // Complete immediately: plain ALU result or rejected access
                        wb_valid_d = 1'b1;
                        wb_data_d  = alu_data_i;
                        wb_addr_d  = regc_addr_i;
                        wb_wr_d    = regc_wr_i && !in_misalign;
                        misalign_d = in_misalign;
                    end else begin
                        addr_d      = {mem_addr_i[31:2], 2'b00};
                        we_d        = mem_wr_i;
                        wdata_d     = steered_wdata;
                        wstrb_d     = mem_wr_i ? (wmask_i << in_off) : 4'b0000;
                        ld_off_d    = in_off;
                        ld_mask_d   = rmask_i;
                        ld_signed_d = load_signed_i;
                        ld_en_d     = mem_rd_i && !mem_wr_i;
                        alu_d       = alu_data_i;
                        regc_wr_d   = regc_wr_i;
                        regc_addr_d = regc_addr_i;
                    end
                end
            end
            StReq: begin
                if (bus.dm_ack) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_en_q ? load_value : alu_q;
                    wb_addr_d  = regc_addr_q;
                    wb_wr_d    = regc_wr_q;
                end else if (timeout_hit) begin
                    wb_valid_d = 1'b1;
                    wb_data_d  = TimeoutData;
                    wb_addr_d  = regc_addr_q;
                    wb_wr_d    = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            ld_off_q    <= '0;
            ld_mask_q   <= '0;
            ld_signed_q <= 1'b0;
            ld_en_q     <= 1'b0;
            alu_q       <= '0;
            regc_wr_q   <= 1'b0;
            regc_addr_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_addr_q   <= '0;
            wb_wr_q     <= 1'b0;
            misalign_q  <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            ld_off_q    <= ld_off_d;
            ld_mask_q   <= ld_mask_d;
            ld_signed_q <= ld_signed_d;
            ld_en_q     <= ld_en_d;
            alu_q       <= alu_d;
            regc_wr_q   <= regc_wr_d;
            regc_addr_q <= regc_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_addr_q   <= wb_addr_d;
            wb_wr_q     <= wb_wr_d;
            misalign_q  <= misalign_d;
        end
    end

    // Bus outputs come straight from state/latched fields so reset clears them at once
    assign bus.dm_req   = (state_q == StReq);
    assign bus.dm_we    = we_q;
    assign bus.dm_addr  = addr_q;
    assign bus.dm_wdata = wdata_q;
    assign bus.dm_wstrb = wstrb_q;

    assign wb_valid = wb_valid_q;
    assign wb_data  = wb_data_q;
    assign wb_addr  = wb_addr_q;
    assign wb_wr    = wb_wr_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit. Covers the timeout path when built with
// MEM_TIMEOUT_EN.
module tb_mem_access_unit;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_data_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        mem_rd_i;
    logic        mem_wr_i;
    logic [3:0]  rmask_i;
    logic [3:0]  wmask_i;
    logic        load_signed_i;
    logic        regc_wr_i;
    logic [4:0]  regc_addr_i;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_addr;
    logic        wb_wr;
    logic        misalign;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_err;
`endif

    int unsigned n_checks;
    int unsigned n_fails;

    mem_access_unit_if bus ();

    mem_access_unit #(
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_data_i   (alu_data_i),
        .mem_addr_i   (mem_addr_i),
        .mem_wdata_i  (mem_wdata_i),
        .mem_rd_i     (mem_rd_i),
        .mem_wr_i     (mem_wr_i),
        .rmask_i      (rmask_i),
        .wmask_i      (wmask_i),
        .load_signed_i(load_signed_i),
        .regc_wr_i    (regc_wr_i),
        .regc_addr_i  (regc_addr_i),
        .bus          (bus.master),
        .wb_valid     (wb_valid),
        .wb_data      (wb_data),
        .wb_addr      (wb_addr),
        .wb_wr        (wb_wr),
`ifdef MEM_TIMEOUT_EN
        .timeout_err  (timeout_err),
`endif
        .misalign     (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to 1 time unit past the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one packet for a single cycle; returns 1 after the accepting edge
    task automatic send(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] alu,
                        input logic [3:0] rmask, input logic [3:0] wmask,
                        input logic sgn, input logic rwr, input logic [4:0] raddr);
        mem_rd_i      = rd;
        mem_wr_i      = wr;
        mem_addr_i    = addr;
        mem_wdata_i   = wdata;
        alu_data_i    = alu;
        rmask_i       = rmask;
        wmask_i       = wmask;
        load_signed_i = sgn;
        regc_wr_i     = rwr;
        regc_addr_i   = raddr;
        in_valid      = 1'b1;
        tick();
        in_valid      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        alu_data_i = '0;
        mem_addr_i = '0;
        mem_wdata_i = '0;
        mem_rd_i = 1'b0;
        mem_wr_i = 1'b0;
        rmask_i = '0;
        wmask_i = '0;
        load_signed_i = 1'b0;
        regc_wr_i = 1'b0;
        regc_addr_i = '0;
        bus.dm_rdata = '0;
        bus.dm_ack = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_dm_req", 32'(bus.dm_req), 32'd0);
        check("rst_wb_valid", 32'(wb_valid), 32'd0);
        check("rst_wb_data", wb_data, 32'd0);
        check("rst_misalign", 32'(misalign), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // ALU packet
        send(1'b0, 1'b0, 32'h0, 32'h0, 32'h12345678, 4'h0, 4'h0, 1'b0, 1'b1, 5'd5);
        check("alu_wb_valid", 32'(wb_valid), 32'd1);
        check("alu_wb_data", wb_data, 32'h12345678);
        check("alu_wb_addr", 32'(wb_addr), 32'd5);
        check("alu_wb_wr", 32'(wb_wr), 32'd1);
        check("alu_in_ready", 32'(in_ready), 32'd1);
        check("alu_no_req", 32'(bus.dm_req), 32'd0);
        tick();
        check("alu_wb_pulse", 32'(wb_valid), 32'd0);

        // Byte store at 0x1003, ack in third request cycle
        send(1'b0, 1'b1, 32'h1003, 32'h000000AB, 32'h1003, 4'h0, 4'b0001, 1'b0, 1'b0, 5'd7);
        check("st_dm_addr", bus.dm_addr, 32'h1000);
        check("st_dm_wstrb", 32'(bus.dm_wstrb), 32'h8);
        check("st_dm_wdata", bus.dm_wdata, 32'hABABABAB);
        check("st_dm_we", 32'(bus.dm_we), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("st_dm_req", 32'(bus.dm_req), 32'd1);
            check("st_in_ready", 32'(in_ready), 32'd0);
            check("st_wb_idle", 32'(wb_valid), 32'd0);
            if (i == 2) bus.dm_ack = 1'b1;
            tick();
        end
        bus.dm_ack = 1'b0;
        check("st_wb_valid", 32'(wb_valid), 32'd1);
        check("st_wb_wr", 32'(wb_wr), 32'd0);
        check("st_resp_in_ready", 32'(in_ready), 32'd0);
        check("st_resp_req", 32'(bus.dm_req), 32'd0);
        tick();
        check("st_wb_pulse", 32'(wb_valid), 32'd0);
        check("st_back_ready", 32'(in_ready), 32'd1);

        // Half loads at 0x2002 with immediate ack, signed then unsigned
        bus.dm_rdata = 32'h80011234;
        for (int s = 1; s >= 0; s--) begin
            send(1'b1, 1'b0, 32'h2002, 32'h0, 32'h2002, 4'b0011, 4'h0, s[0], 1'b1, 5'd9);
            check("ldh_dm_req", 32'(bus.dm_req), 32'd1);
            check("ldh_dm_we", 32'(bus.dm_we), 32'd0);
            bus.dm_ack = 1'b1;
            tick();
            bus.dm_ack = 1'b0;
            check("ldh_wb_valid", 32'(wb_valid), 32'd1);
            check("ldh_wb_data", wb_data, (s == 1) ? 32'hFFFF8001 : 32'h00008001);
            check("ldh_wb_addr", 32'(wb_addr), 32'd9);
            check("ldh_wb_wr", 32'(wb_wr), 32'd1);
            tick();
        end

        // Signed byte loads at lanes 1 and 3
        send(1'b1, 1'b0, 32'h2001, 32'h0, 32'h0, 4'b0001, 4'h0, 1'b1, 1'b1, 5'd10);
        bus.dm_ack = 1'b1;
        tick();
        bus.dm_ack = 1'b0;
        check("ldb1_wb_data", wb_data, 32'h00000012);
        tick();
        send(1'b1, 1'b0, 32'h2003, 32'h0, 32'h0, 4'b0001, 4'h0, 1'b1, 1'b1, 5'd10);
        bus.dm_ack = 1'b1;
        tick();
        bus.dm_ack = 1'b0;
        check("ldb3_wb_data", wb_data, 32'hFFFFFF80);
        tick();

        // Aligned half store in upper half
        send(1'b0, 1'b1, 32'h4002, 32'h00001234, 32'h0, 4'h0, 4'b0011, 1'b0, 1'b0, 5'd0);
        check("sth_dm_wstrb", 32'(bus.dm_wstrb), 32'hC);
        check("sth_dm_wdata", bus.dm_wdata, 32'h12341234);
        bus.dm_ack = 1'b1;
        tick();
        bus.dm_ack = 1'b0;
        tick();

        // Load and store together: store wins
        bus.dm_rdata = 32'h11111111;
        send(1'b1, 1'b1, 32'h5000, 32'hCAFEF00D, 32'h00005000, 4'b1111, 4'b1111, 1'b0,
             1'b1, 5'd3);
        check("rw_dm_we", 32'(bus.dm_we), 32'd1);
        check("rw_dm_wdata", bus.dm_wdata, 32'hCAFEF00D);
        check("rw_dm_wstrb", 32'(bus.dm_wstrb), 32'hF);
        bus.dm_ack = 1'b1;
        tick();
        bus.dm_ack = 1'b0;
        check("rw_wb_data", wb_data, 32'h00005000);
        check("rw_wb_wr", 32'(wb_wr), 32'd1);
        tick();

        // Misaligned word load
        send(1'b1, 1'b0, 32'h3001, 32'h0, 32'h3001, 4'b1111, 4'h0, 1'b0, 1'b1, 5'd4);
        check("mis_dm_req", 32'(bus.dm_req), 32'd0);
        check("mis_misalign", 32'(misalign), 32'd1);
        check("mis_wb_valid", 32'(wb_valid), 32'd1);
        check("mis_wb_wr", 32'(wb_wr), 32'd0);
        check("mis_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("mis_pulse", 32'(misalign), 32'd0);

        // Misaligned half store
        send(1'b0, 1'b1, 32'h4001, 32'h0, 32'h0, 4'h0, 4'b0011, 1'b0, 1'b0, 5'd0);
        check("mish_misalign", 32'(misalign), 32'd1);
        check("mish_dm_req", 32'(bus.dm_req), 32'd0);
        tick();

        // Reset while in REQ
        send(1'b1, 1'b0, 32'h7000, 32'h0, 32'h0, 4'b1111, 4'h0, 1'b0, 1'b1, 5'd8);
        check("rreq_dm_req", 32'(bus.dm_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("rreq_req_drop", 32'(bus.dm_req), 32'd0);
        check("rreq_in_ready", 32'(in_ready), 32'd0);
        check("rreq_dm_addr", bus.dm_addr, 32'd0);
        check("rreq_wb_data", wb_data, 32'd0);
        check("rreq_wb_valid", 32'(wb_valid), 32'd0);
        tick();
        rst = 1'b0;
        bus.dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rreq_no_wb", 32'(wb_valid), 32'd0);
        end
        bus.dm_ack = 1'b0;

`ifdef MEM_TIMEOUT_EN
        // No ack: abort after four request cycles
        send(1'b1, 1'b0, 32'h6000, 32'h0, 32'h0, 4'b1111, 4'h0, 1'b0, 1'b1, 5'd6);
        for (int i = 0; i < 4; i++) begin
            check("to_dm_req", 32'(bus.dm_req), 32'd1);
            check("to_err_low", 32'(timeout_err), 32'd0);
            tick();
        end
        check("to_err", 32'(timeout_err), 32'd1);
        check("to_wb_valid", 32'(wb_valid), 32'd1);
        check("to_wb_data", wb_data, 32'hDEADBEEF);
        check("to_wb_wr", 32'(wb_wr), 32'd0);
        check("to_req_drop", 32'(bus.dm_req), 32'd0);
        check("to_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("to_err_pulse", 32'(timeout_err), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
